// File: rtl/memoria_instrucao_mp_if.sv
// Loader and fetch bus of the multi-process instruction memory.
// master: HD loader / fetch stage side; slave: the memory.
interface memoria_instrucao_mp_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16,
    parameter int PROC_W = 4
);
    logic              carga_inicio;
    logic [PROC_W-1:0] carga_proc;
    logic              carga_valido;
    logic [DATA_W-1:0] carga_dado;
    logic              carga_ultimo;
    logic              carga_pronto;
    logic              carga_fim;
    logic              carga_erro;
    logic [PROC_W-1:0] processo;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instrucao_saida;
    logic              falha;

    modport master (
        output carga_inicio, carga_proc, carga_valido, carga_dado, carga_ultimo,
        output processo, pc,
        input  carga_pronto, carga_fim, carga_erro, instrucao_saida, falha
    );

    modport slave (
        input  carga_inicio, carga_proc, carga_valido, carga_dado, carga_ultimo,
        input  processo, pc,
        output carga_pronto, carga_fim, carga_erro, instrucao_saida, falha
    );
endinterface

// File: rtl/memoria_instrucao_mp.sv
// Multi-process instruction memory: one partition per process, filled by a
// valid/ready loader FSM, served by a bounds-checked registered fetch.
// Optional boot image in partition 0: define MEMINSTR_BOOT_EN.
module memoria_instrucao_mp #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 16,
    parameter int NUM_PROC = 8,
    parameter int DEPTH    = 64,
    parameter int PROC_W   = 4
) (
    input logic                   clk,
    input logic                   reset,
    memoria_instrucao_mp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam logic [AW:0] END_MAX = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {BOOT0, BOOT1, OCIOSO, CARGA, FIM} state_t;
    state_t state;

    logic [DATA_W-1:0]           mem [NUM_PROC][DEPTH];
    logic [NUM_PROC-1:0][AW-1:0] tam;
    logic [NUM_PROC-1:0]         ok;
    logic [AW:0]                 end_ptr;
    logic [PW-1:0]               cur_proc;
    logic                        pronto_q;
    logic                        fim_q;
    logic                        erro_q;
    logic [DATA_W-1:0]           instr_q;
    logic                        falha_q;

    logic              ld_proc_ok;
    logic              overflow;
    logic              wr_en;
    logic [PW-1:0]     wr_proc;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [PW-1:0]     f_proc;
    logic [AW-1:0]     f_addr;
    logic              hit;

    assign ld_proc_ok = 32'(bus.carga_proc) < NUM_PROC;
    assign overflow   = (end_ptr == END_MAX);

    assign bus.carga_pronto    = pronto_q;
    assign bus.carga_fim       = fim_q;
    assign bus.carga_erro      = erro_q;
    assign bus.instrucao_saida = instr_q;
    assign bus.falha           = falha_q;

    // Single write port shared by the boot sequence and the loader stream.
    always_comb begin
        wr_en   = 1'b0;
        wr_proc = cur_proc;
        wr_addr = end_ptr[AW-1:0];
        wr_data = bus.carga_dado;
        case (state)
`ifdef MEMINSTR_BOOT_EN
            BOOT0: begin
                wr_en   = 1'b1;
                wr_proc = '0;
                wr_addr = AW'(1);
                wr_data = DATA_W'(32'hC8020002);
            end
            BOOT1: begin
                wr_en   = 1'b1;
                wr_proc = '0;
                wr_addr = AW'(2);
                wr_data = DATA_W'(32'hD0020000);
            end
`endif
            CARGA:   wr_en = bus.carga_valido && !overflow;
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_proc][wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef MEMINSTR_BOOT_EN
            state    <= BOOT0;
            pronto_q <= 1'b0;
`else
            state    <= OCIOSO;
            pronto_q <= 1'b1;
`endif
            fim_q    <= 1'b0;
            erro_q   <= 1'b0;
            end_ptr  <= '0;
            cur_proc <= '0;
            tam      <= '0;
            ok       <= '0;
        end else begin
            fim_q  <= 1'b0;
            erro_q <= 1'b0;
            case (state)
`ifdef MEMINSTR_BOOT_EN
                BOOT0: state <= BOOT1;
                BOOT1: begin
                    tam[0]   <= AW'(2);
                    ok[0]    <= 1'b1;
                    state    <= OCIOSO;
                    pronto_q <= 1'b1;
                end
`endif
                OCIOSO: begin
                    if (bus.carga_inicio) begin
                        if (ld_proc_ok) begin
                            ok[PW'(bus.carga_proc)] <= 1'b0;
                            cur_proc <= PW'(bus.carga_proc);
                            end_ptr  <= (AW+1)'(1);
                            state    <= CARGA;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end
                end
                CARGA: begin
                    if (bus.carga_valido) begin
                        // Full partition: drop the word, keep the partial length, leave ok cleared.
                        if (overflow) begin
                            erro_q   <= 1'b1;
                            fim_q    <= 1'b1;
                            pronto_q <= 1'b0;
                            state    <= FIM;
                        end else begin
                            tam[cur_proc] <= end_ptr[AW-1:0];
                            end_ptr       <= end_ptr + (AW+1)'(1);
                            if (bus.carga_ultimo) begin
                                ok[cur_proc] <= 1'b1;
                                fim_q        <= 1'b1;
                                pronto_q     <= 1'b0;
                                state        <= FIM;
                            end
                        end
                    end
                end
                FIM: begin
                    state    <= OCIOSO;
                    pronto_q <= 1'b1;
                end
                default: begin
                    state    <= OCIOSO;
                    pronto_q <= 1'b1;
                end
            endcase
        end
    end

    assign f_proc = PW'(bus.processo);
    assign f_addr = AW'(bus.pc);
    assign hit    = (32'(bus.processo) < NUM_PROC) && ok[f_proc]
                  && ((bus.pc >> AW) == '0)
                  && (f_addr != '0) && (f_addr <= tam[f_proc]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            falha_q <= 1'b0;
        end else if (hit) begin
            instr_q <= mem[f_proc][f_addr];
            falha_q <= 1'b0;
        end else begin
            instr_q <= '0;
            falha_q <= 1'b1;
        end
    end
endmodule
